// File: rtl/drp_pll_responder_pkg.sv
// Shared definitions for the DRP PLL responder: FSM encoding, well-known
// register addresses and the power-on contents of the register array.
package drp_pll_responder_pkg;

  // Transaction FSM: accept in IDLE, count down in WAIT, pulse drdy in ACK.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } drp_state_e;

  // Clock-output divider registers.
  localparam logic [6:0] REG_CLKOUT_LO = 7'h08;
  localparam logic [6:0] REG_CLKOUT_HI = 7'h09;

  // Power-on values: divider high=1, low=1, phase=0; everything else zero.
  localparam logic [15:0] RST_CLKOUT_LO = 16'h1041;
  localparam logic [15:0] RST_CLKOUT_HI = 16'h0000;
  localparam logic [15:0] RST_DEFAULT   = 16'h0000;

  // Width of the latency down-counter (LATENCY is at most 15).
  localparam int CNT_W = 4;

  // Reset value for array entry idx.
  function automatic logic [15:0] reg_reset_value(input int unsigned idx);
    logic [15:0] val;
    val = RST_DEFAULT;
    if (idx == 32'(REG_CLKOUT_LO)) begin
      val = RST_CLKOUT_LO;
    end else if (idx == 32'(REG_CLKOUT_HI)) begin
      val = RST_CLKOUT_HI;
    end
    return val;
  endfunction

endpackage

// File: rtl/drp_regbank.sv
// Register array behind the DRP responder: one write port, one
// combinational read port, reset loader, and fixed taps of the clock-output
// divider fields. Entries are individual flops so they can take non-zero
// reset values and feed the cfg taps directly.
module drp_regbank
  import drp_pll_responder_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [5:0]        cfg_high,
  output logic [5:0]        cfg_low,
  output logic [5:0]        cfg_phase
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_q;
    logic [DATA_W-1:0] entry_d;

    // Full-width address decode, so every address maps to its own entry.
    always_comb begin
      entry_d = entry_q;
      if (wr_en && (wr_addr == ADDR_W'(gi))) begin
        entry_d = wr_data;
      end
    end

    // Entry storage; reset reloads the power-on value.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= DATA_W'(reg_reset_value(gi));
      end else begin
        entry_q <= entry_d;
      end
    end

    assign mem[gi] = entry_q;
  end

  assign rd_data   = mem[rd_addr];

  // Divider taps follow the stored words, so they move the cycle after a write.
  assign cfg_high  = mem[REG_CLKOUT_LO][11:6];
  assign cfg_low   = mem[REG_CLKOUT_LO][5:0];
  assign cfg_phase = mem[REG_CLKOUT_HI][5:0];

endmodule

// File: rtl/drp_pll_responder.sv
// DRP responder for the PLL configuration space. A request accepted in IDLE
// is held for LATENCY cycles, completes with a one-cycle drdy, and a write
// commits to the register array at the end of that drdy cycle. Requests that
// arrive while a transaction is in flight are dropped and flagged in err_ovl.
module drp_pll_responder
  import drp_pll_responder_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              den,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout,
  output logic              drdy,
  output logic              busy,
  output logic              err_ovl,
  input  logic              err_clr,
  output logic [5:0]        cfg_high,
  output logic [5:0]        cfg_low,
  output logic [5:0]        cfg_phase
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  drp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              drdy_q, drdy_d;
  logic              busy_q, busy_d;
  logic              err_ovl_q, err_ovl_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // The read port looks at the address that will be latched this cycle, so
  // read data is ready to register even when LATENCY=1 goes IDLE -> ACK.
  assign rd_addr = ((state_q == ST_IDLE) && den) ? daddr : addr_q;

  // The write commits at the edge that ends the ACK cycle.
  assign wr_en = (state_q == ST_ACK) && we_q;

  drp_regbank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regbank (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (addr_q),
    .wr_data   (wdata_q),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_phase (cfg_phase)
  );

  // Next-state logic: accept in IDLE, count in WAIT, single ACK cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (den) begin
          addr_d  = daddr;
          we_d    = dwe;
          wdata_d = di;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the next state; set beats clear on err_ovl.
  always_comb begin
    drdy_d    = (state_d == ST_ACK);
    busy_d    = (state_d != ST_IDLE);
    dout_d    = '0;
    if ((state_d == ST_ACK) && !we_d) begin
      dout_d = rd_data;
    end
    err_ovl_d = err_ovl_q;
    if (err_clr) begin
      err_ovl_d = 1'b0;
    end
    if (den && (state_q != ST_IDLE)) begin
      err_ovl_d = 1'b1;
    end
  end

  // FSM and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      drdy_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_ovl_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      drdy_q    <= drdy_d;
      busy_q    <= busy_d;
      err_ovl_q <= err_ovl_d;
      dout_q    <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign drdy    = drdy_q;
  assign busy    = busy_q;
  assign err_ovl = err_ovl_q;

endmodule

// File: tb/tb_drp_pll_responder.sv
// Directed bench for drp_pll_responder: one instance at LATENCY=3 and one at
// LATENCY=1 sharing clock, reset and request fields. Expected completions
// (data and cycle) are queued when a request is driven and checked when drdy
// appears.
module tb_drp_pll_responder;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk_in;
  logic        rst_n;
  logic        den3, den1;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        err_clr;

  logic [15:0] dout3, dout1;
  logic        drdy3, drdy1;
  logic        busy3, busy1;
  logic        err3, err1;
  logic [5:0]  cfg_high3, cfg_low3, cfg_phase3;
  logic [5:0]  cfg_high1, cfg_low1, cfg_phase1;

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb3[$];
  exp_t sb1[$];

  drp_pll_responder #(.ADDR_W(7), .DATA_W(16), .LATENCY(3)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .den(den3), .dwe(dwe), .daddr(daddr),
    .di(di), .dout(dout3), .drdy(drdy3), .busy(busy3), .err_ovl(err3),
    .err_clr(err_clr), .cfg_high(cfg_high3), .cfg_low(cfg_low3),
    .cfg_phase(cfg_phase3)
  );

  drp_pll_responder #(.ADDR_W(7), .DATA_W(16), .LATENCY(1)) dut_l1 (
    .clk_in(clk_in), .rst_n(rst_n), .den(den1), .dwe(dwe), .daddr(daddr),
    .di(di), .dout(dout1), .drdy(drdy1), .busy(busy1), .err_ovl(err1),
    .err_clr(err_clr), .cfg_high(cfg_high1), .cfg_low(cfg_low1),
    .cfg_phase(cfg_phase1)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drive one request to the LATENCY=3 instance; optionally queue its completion.
  task automatic drive3(input logic we, input logic [6:0] a, input logic [15:0] d,
                        input logic push, input logic [15:0] expd);
    den3 = 1'b1; dwe = we; daddr = a; di = d;
    if (push) sb3.push_back('{data: expd, cyc: cyc + 3});
    tick();
    den3 = 1'b0; dwe = 1'b0;
  endtask

  // Drive one request to the LATENCY=1 instance and queue its completion.
  task automatic drive1(input logic we, input logic [6:0] a, input logic [15:0] d,
                        input logic [15:0] expd);
    den1 = 1'b1; dwe = we; daddr = a; di = d;
    sb1.push_back('{data: expd, cyc: cyc + 1});
    tick();
    den1 = 1'b0; dwe = 1'b0;
  endtask

  // Bounded wait for both scoreboards to drain.
  task automatic wait_idle();
    int i;
    i = 0;
    while ((sb3.size() != 0 || sb1.size() != 0) && i < 40) begin
      tick();
      i++;
    end
    check("drain_timeout", 32'(sb3.size() + sb1.size()), 0);
    tick();
  endtask

  // Completion monitor for the LATENCY=3 instance.
  always @(negedge clk_in) begin
    exp_t e;
    if (drdy3) begin
      if (sb3.size() == 0) begin
        check("l3_unexpected_drdy", {31'b0, drdy3}, 0);
      end else begin
        e = sb3.pop_front();
        $display("L3 drdy cycle=%0d dout=%h", cyc, dout3);
        check("l3_dout", {16'b0, dout3}, {16'b0, e.data});
        check("l3_drdy_cycle", cyc, e.cyc);
      end
    end else begin
      check("l3_dout_idle", {16'b0, dout3}, 0);
    end
  end

  // Completion monitor for the LATENCY=1 instance.
  always @(negedge clk_in) begin
    exp_t e;
    if (drdy1) begin
      if (sb1.size() == 0) begin
        check("l1_unexpected_drdy", {31'b0, drdy1}, 0);
      end else begin
        e = sb1.pop_front();
        $display("L1 drdy cycle=%0d dout=%h", cyc, dout1);
        check("l1_dout", {16'b0, dout1}, {16'b0, e.data});
        check("l1_drdy_cycle", cyc, e.cyc);
      end
    end else begin
      check("l1_dout_idle", {16'b0, dout1}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0]  a;
    logic [15:0] d;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; den3 = 1'b0; den1 = 1'b0; dwe = 1'b0;
    daddr = '0; di = '0; err_clr = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_drdy",      {31'b0, drdy3}, 0);
    check("rst_busy",      {31'b0, busy3}, 0);
    check("rst_err",       {31'b0, err3}, 0);
    check("rst_cfg_high",  {26'b0, cfg_high3}, 1);
    check("rst_cfg_low",   {26'b0, cfg_low3}, 1);
    check("rst_cfg_phase", {26'b0, cfg_phase3}, 0);
    check("rst_l1_cfg_low", {26'b0, cfg_low1}, 1);

    // Read 0x08 right after reset release: accepted on the first edge.
    rst_n = 1'b1;
    drive3(1'b0, 7'h08, 16'h0000, 1'b1, 16'h1041);
    check("wait_busy", {31'b0, busy3}, 1);
    wait_idle();

    // Write 0x08, watch cfg taps move the cycle after commit, then read back.
    drive3(1'b1, 7'h08, 16'h0F83, 1'b1, 16'h0000);
    tick(); tick();
    check("cfg_high_during_ack", {26'b0, cfg_high3}, 1);
    tick();
    check("cfg_high_after_wr", {26'b0, cfg_high3}, 6'h3E);
    check("cfg_low_after_wr",  {26'b0, cfg_low3}, 6'h03);
    drive3(1'b0, 7'h08, 16'h0000, 1'b1, 16'h0F83);
    wait_idle();

    // Write 0x09, overlapping request in the second WAIT cycle is dropped.
    drive3(1'b1, 7'h09, 16'h0005, 1'b1, 16'h0000);
    tick();
    drive3(1'b0, 7'h08, 16'h0000, 1'b0, 16'h0000);
    check("ovl_set", {31'b0, err3}, 1);
    wait_idle();
    check("ovl_sticky", {31'b0, err3}, 1);
    check("cfg_phase_after_wr", {26'b0, cfg_phase3}, 6'h05);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovl_cleared", {31'b0, err3}, 0);

    // Overlap and err_clr in the same cycle: set wins.
    drive3(1'b0, 7'h09, 16'h0000, 1'b1, 16'h0005);
    err_clr = 1'b1;
    drive3(1'b0, 7'h08, 16'h0000, 1'b0, 16'h0000);
    err_clr = 1'b0;
    check("ovl_set_wins", {31'b0, err3}, 1);
    wait_idle();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovl_cleared2", {31'b0, err3}, 0);

    // Reset in WAIT of a write to 0x10: aborted, no drdy, no write.
    drive3(1'b1, 7'h10, 16'hABCD, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy3}, 0);
    check("abort_drdy", {31'b0, drdy3}, 0);
    tick(); tick();
    check("reload_cfg_high",  {26'b0, cfg_high3}, 1);
    check("reload_cfg_phase", {26'b0, cfg_phase3}, 0);
    rst_n = 1'b1;
    drive3(1'b0, 7'h10, 16'h0000, 1'b1, 16'h0000);
    wait_idle();

    // LATENCY=1: fill both address extremes, then back-to-back reads every 2 cycles.
    drive1(1'b1, 7'h00, 16'h1111, 16'h0000); tick();
    drive1(1'b1, 7'h7F, 16'h7F7F, 16'h0000); tick();
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 1) ? 7'h7F : 7'h00;
      d = (i % 2 == 1) ? 16'h7F7F : 16'h1111;
      drive1(1'b0, a, 16'h0000, d);
      tick();
    end
    wait_idle();
    check("l1_no_ovl", {31'b0, err1}, 0);
    check("l1_idle_busy", {31'b0, busy1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
